// File: rtl/add_share_sched.sv
`timescale 1ns/1ps
// add_share_sched: round-robin sharing of one external combinational W-bit adder
// among N requesters. Operands are latched on accept, driven interleaved on
// add_in, and the result is captured after ADDER_LAT cycles and returned on a
// valid/ready channel tagged with the requester index.
// Optional per-requester saturating grant counters: define ADD_SHARE_SCHED_STATS_EN.

`ifdef ADD_SHARE_SCHED_STATS_EN
// Saturating 8-bit grant counter for one requester.
module add_share_sched_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] cnt
);
  // count accepts, stick at all-ones, clear only on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   cnt <= '0;
    else if (inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
endmodule
`endif

module add_share_sched #(
  parameter int N         = 4,
  parameter int W         = 12,
  parameter int ADDER_LAT = 1,
  parameter int IDW       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [2*W-1:0]   add_in,
  input  logic [W:0]       add_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_sum,
  output logic             rsp_cout,
  output logic [N*8-1:0]   grant_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } rsp_t;

  localparam logic [3:0] LAT = 4'(ADDER_LAT);

  state_t         state, state_nxt;
  logic [1:0]     rst_sync;
  logic           run;
  logic [IDW-1:0] rr_ptr, win;
  logic           win_vld, accept;
  logic [W-1:0]   op_a, op_b;
  logic [3:0]     cnt;
  rsp_t           rsp_q;

  // grants are held off until reset release has been synchronised to clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};

  assign run = rst_sync[1];

  // rotating-priority search starting at rr_ptr, wrapping mod N
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  assign accept = (state == IDLE) && run && win_vld;

  // one-hot accept strobe, only in the transfer cycle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next-state: accept -> settle for ADDER_LAT cycles -> hold response until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd1)    state_nxt = RESP;
      RESP:    if (rsp_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // operand latch on accept, settle countdown, result capture on the last settle cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      rsp_q  <= '0;
    end else if (accept) begin
      op_a     <= req_a[win*W +: W];
      op_b     <= req_b[win*W +: W];
      rsp_q.id <= win;
      rr_ptr   <= (int'(win) == N-1) ? '0 : win + IDW'(1);
      cnt      <= LAT;
    end else if (state == SETTLE) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        rsp_q.sum  <= add_out[W-1:0];
        rsp_q.cout <= add_out[W];
      end
    end

  // adder bus is bit-interleaved: even bits carry A, odd bits carry B
  always_comb begin
    add_in = '0;
    for (int k = 0; k < W; k++) begin
      add_in[2*k]   = op_a[k];
      add_in[2*k+1] = op_b[k];
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;

`ifdef ADD_SHARE_SCHED_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_cnt
    add_share_sched_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (req_ready[i]),
      .cnt   (grant_cnt[i*8 +: 8])
    );
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_add_share_sched.sv
`timescale 1ns/1ps
// Bench for add_share_sched: a LAT=1 instance driven by directed and random
// stimulus against a transaction-level model, plus a LAT=3 instance whose
// adder only produces a correct sum once its inputs have been stable 3 cycles.
module tb_add_share_sched;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int L1 = 1;
  localparam int L3 = 3;
`ifdef ADD_SHARE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, req_valid3, req_ready3;
  logic [N*W-1:0] req_a, req_b, req_a3, req_b3;
  logic [2*W-1:0] add_in, add_in3;
  logic [W:0]     add_out, add_out3;
  logic           rsp_valid, rsp_ready, rsp_valid3, rsp_ready3;
  logic [1:0]     rsp_id, rsp_id3;
  logic [W-1:0]   rsp_sum, rsp_sum3;
  logic           rsp_cout, rsp_cout3;
  logic [N*8-1:0] grant_cnt, grant_cnt3;

  add_share_sched #(.N(N), .W(W), .ADDER_LAT(L1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_in(add_in), .add_out(add_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .grant_cnt(grant_cnt));

  add_share_sched #(.N(N), .W(W), .ADDER_LAT(L3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .add_in(add_in3), .add_out(add_out3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3),
    .grant_cnt(grant_cnt3));

  function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    for (int k = 0; k < W; k++) begin r[2*k] = a[k]; r[2*k+1] = b[k]; end
    return r;
  endfunction

  function automatic logic [W:0] add_of(input logic [2*W-1:0] ai);
    logic [W-1:0] a, b;
    for (int k = 0; k < W; k++) begin a[k] = ai[2*k]; b[k] = ai[2*k+1]; end
    return {1'b0, a} + {1'b0, b};
  endfunction

  // slow adder for the LAT=3 instance: wrong (inverted) result until inputs settle
  logic [2*W-1:0] last3 = '0;
  int age3 = 0;
  int eff3;
  always @(posedge clk) begin
    last3 <= add_in3;
    age3  <= (add_in3 == last3) ? ((age3 < 15) ? age3 + 1 : 15) : 1;
  end
  assign eff3     = (add_in3 == last3) ? age3 + 1 : 1;
  assign add_out  = add_of(add_in);
  assign add_out3 = (eff3 >= L3) ? add_of(add_in3) : ~add_of(add_in3);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // transaction-level model of the LAT=1 instance
  int             m_ptr = 0;
  bit             m_busy = 1'b0;
  int             m_rsp_cyc = 0;
  logic [1:0]     m_id = '0;
  logic [W:0]     m_sum = '0;
  logic [2*W-1:0] m_ai = '0;
  int             grants [N];
  int             cyc = 0;
  int             g_last = -1;

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(3, 0))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // called at a negedge: check this cycle against the model, then step to the next negedge
  task automatic tick();
    logic [N-1:0]   er;
    logic [2*W-1:0] nai;
    logic [7:0]     eg;
    bit             ev;
    int             w;
    #1;
    ev = m_busy && (cyc >= m_rsp_cyc);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_sum", rsp_sum, m_sum[W-1:0]);
      chk("rsp_cout", rsp_cout, m_sum[W]);
    end
    chk("add_in", add_in, m_ai);
    for (int i = 0; i < N; i++) begin
      eg = STATS ? ((grants[i] > 255) ? 8'hFF : 8'(grants[i])) : 8'h00;
      chk("grant_cnt", grant_cnt[i*8 +: 8], eg);
    end
    er = '0; g_last = -1; nai = m_ai;
    if (!m_busy) begin
      w = pick();
      if (w >= 0) begin
        er[w]     = 1'b1;
        g_last    = w;
        m_busy    = 1'b1;
        m_rsp_cyc = cyc + L1 + 1;
        m_id      = 2'(w);
        m_sum     = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
        nai       = ilv(req_a[w*W +: W], req_b[w*W +: W]);
        m_ptr     = (w + 1) % N;
        grants[w]++;
      end
    end
    chk("req_ready", req_ready, er);
    if (ev && rsp_ready) m_busy = 1'b0;
    @(negedge clk);
    cyc++;
    m_ai = nai;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"},    rsp_id, '0);
    chk({tag, "_rsp_sum"},   rsp_sum, '0);
    chk({tag, "_rsp_cout"},  rsp_cout, 1'b0);
    chk({tag, "_add_in"},    add_in, '0);
    chk({tag, "_grant_cnt"}, grant_cnt, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    #1 zero_chk("reset");
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // LAT=3: 800+800 must be held 3 cycles, response on cycle 4
    req_a3[W-1:0] = 12'h800; req_b3[W-1:0] = 12'h800; req_valid3 = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_ready3 != '0) break;
      @(negedge clk);
    end
    chk("l3_accept", req_ready3, 4'b0001);
    @(negedge clk);
    req_valid3 = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("l3_add_in", add_in3, ilv(12'h800, 12'h800));
      chk("l3_rsp_valid", rsp_valid3, c == 4);
      chk("l3_req_ready", req_ready3, '0);
      if (c == 4) begin
        chk("l3_rsp_sum", rsp_sum3, 12'h000);
        chk("l3_rsp_cout", rsp_cout3, 1'b1);
        chk("l3_rsp_id", rsp_id3, 2'd0);
      end
      @(negedge clk);
    end

    // single request: FFF + 001 wraps to 000 with carry
    req_a[W-1:0] = 12'hFFF; req_b[W-1:0] = 12'h001; req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();

    // all requesters valid, consumer always ready
    for (int i = 0; i < N; i++) begin req_a[i*W +: W] = rnd_op(); req_b[i*W +: W] = rnd_op(); end
    req_valid = '1;
    repeat (20) begin
      tick();
      if (g_last >= 0) begin req_a[g_last*W +: W] = rnd_op(); req_b[g_last*W +: W] = rnd_op(); end
    end

    // backpressure: 123+456 held while requester 2 waits
    req_valid = '0;
    repeat (4) tick();
    req_a[W-1:0] = 12'h123; req_b[W-1:0] = 12'h456; req_valid = 4'b0001; rsp_ready = 1'b0;
    tick();
    req_a[2*W +: W] = rnd_op(); req_b[2*W +: W] = rnd_op(); req_valid = 4'b0100;
    repeat (7) tick();
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_sum", rsp_sum, 12'h579);
    chk("bp_rsp_cout", rsp_cout, 1'b0);
    rsp_ready = 1'b1;
    tick();
    tick();
    if (g_last >= 0) req_valid[g_last] = 1'b0;
    repeat (3) tick();

    // random arrivals, occasional withdrawals, random backpressure
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_valid[i] = 1'b1; req_a[i*W +: W] = rnd_op(); req_b[i*W +: W] = rnd_op();
          end
        end else if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(1, 0) == 1);
      tick();
      if (g_last >= 0) req_valid[g_last] = 1'b0;
    end

    // grant counter saturation: requester 1 alone past 255 grants
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 1500 && grants[1] < 300; k++) tick();
    chk("stats_cnt1", grant_cnt[15:8], STATS ? 8'hFF : 8'h00);

    // reset during SETTLE: nothing emitted, pointer restarts at 0
    req_valid = '0;
    repeat (4) tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    rst_n = 1'b0;
    #1 zero_chk("settle_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rst_no_rsp", rsp_valid, 1'b0);
      if (req_ready != '0) break;
      @(negedge clk);
    end
    chk("rst_first_grant", req_ready, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Round-robin scheduler that shares one combinational 12-bit adder (the Brent-Kung prefix adder netlist) among N requesters.
- Latches the granted operand pair into registers and drives the adder's interleaved operand bus.
- Captures the 13-bit result after a configurable settle time and returns it on a valid/ready response channel tagged with the requester ID.
- Sits between client datapaths and the adder instance.

Parameters:
N, 4, number of requesters (2..8)
W, 12, operand width; the adder bus is 2*W in, W+1 out
ADDER_LAT, 1, cycles the operands are held on add_in before add_out is sampled (1..15)
IDW, $clog2(N), response ID width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N  per-requester request
req_a  in  N*W  operand A, requester i at [i*W +: W]
req_b  in  N*W  operand B, same packing
req_ready  out  N  one-hot accept strobe
add_in  out  2*W  adder operand bus, add_in[2k]=A[k], add_in[2k+1]=B[k]
add_out  in  W+1  adder result, bit W = carry out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  requester index of the result
rsp_sum  out  W  add_out[W-1:0] as captured
rsp_cout  out  1  add_out[W] as captured
grant_cnt  out  N*8  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync-released internally):
  - state=IDLE, rr_ptr=0.
  - Registered outputs return to 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_in, grant_cnt.
  - Any in-flight transaction is dropped silently.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap mod N.
  - req_ready[winner]=1 combinationally in that cycle only; that cycle is the transfer.
  - Latch req_a/req_b of the winner into operand registers; add_in reflects them from the next cycle.
  - Store the winner as the ID; rr_ptr <= (winner+1) mod N; load settle counter = ADDER_LAT; go to SETTLE.
  - If no request is pending: stay in IDLE, all req_ready=0.
- SETTLE:
  - add_in is held stable; the counter decrements each cycle.
  - In the cycle the counter equals 1, capture add_out into rsp_sum/rsp_cout and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_cout are stable until rsp_valid&rsp_ready.
  - On the handshake, go to IDLE with rsp_valid=0 the next cycle. No bypass: the next acceptance happens no earlier than the cycle after.
- Latency: with acceptance at cycle 0, rsp_valid rises at cycle ADDER_LAT+1. Minimum issue interval is ADDER_LAT+2 cycles.
- add_in keeps its last operands outside SETTLE; it changes only on acceptance.
- req_ready is never asserted outside IDLE. Requesters hold req_valid and operands until they see req_ready.
- Arithmetic: no width growth beyond W+1; the carry is reported only on rsp_cout.
- Simultaneous events:
  - A request arriving while in RESP waits; it is arbitrated in the next IDLE.
  - A requester deasserting req_valid before grant is simply skipped.

Optional Feature:
- Macro ADD_SHARE_SCHED_STATS_EN.
- When defined:
  - grant_cnt[i*8 +: 8] increments on each acceptance of requester i.
  - The counter saturates at 8'hFF.
  - Counters clear only on reset.
- When undefined: grant_cnt is tied to 0 and no counter flops are built. The port list is unchanged.

Test Plan:
- Single request, ADDER_LAT=1: req_valid[0] with A=12'hFFF, B=12'h001 accepted at cycle 0 -> add_in interleaved from cycle 1; rsp_valid at cycle 2 with rsp_id=0, rsp_sum=12'h000, rsp_cout=1.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one every 3 cycles; each req_ready is a single-cycle one-hot pulse.
- Backpressure: rsp_ready=0 for 5 cycles with A=12'h123, B=12'h456 -> rsp_valid held, rsp_sum=12'h579, rsp_cout=0 stable; req_ready stays 0 for a pending requester 2 until the cycle after the handshake.
- ADDER_LAT=3: A=12'h800, B=12'h800 -> add_in stable for 3 cycles; response at cycle 4 with rsp_sum=0, rsp_cout=1.
- rst_n pulled low during SETTLE -> all outputs 0 immediately, no response emitted; after release the first grant goes to the lowest valid index starting from 0.
- With ADD_SHARE_SCHED_STATS_EN: requester 1 granted 300 times -> grant_cnt[15:8]=8'hFF. Without the macro: grant_cnt=0 throughout.
